// File: rtl/debug_unit_bip.sv
// Host command sequencer for the BIP I core: loads program memory from UART bytes,
// runs the core until HALT and reports PC, ACC and the enabled-cycle count back over UART.
module debug_unit_bip #(
    parameter int WIDTH_WORD  = 8,
    parameter int PC_WIDTH    = 11,
    parameter int INSTR_WIDTH = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_rx_done,
    input  logic [WIDTH_WORD-1:0]  i_data_rx,
    input  logic                   i_tx_done,
    output logic                   o_tx_start,
    output logic [WIDTH_WORD-1:0]  o_data_tx,
    output logic                   o_wr_program,
    output logic [PC_WIDTH-1:0]    o_addr_program,
    output logic [INSTR_WIDTH-1:0] o_data_program,
    output logic                   o_cpu_reset,
    output logic                   o_cpu_enable,
    input  logic                   i_halt,
    input  logic [PC_WIDTH-1:0]    i_pc,
    input  logic [DATA_WIDTH-1:0]  i_acc,
    output logic [2:0]             o_state
);

    localparam int N_REPORT   = 6;
    localparam int REPORT_W   = N_REPORT * WIDTH_WORD;
    localparam int OPCODE_W   = 5;
    localparam logic [WIDTH_WORD-1:0] CMD_LOAD = 8'h01;
    localparam logic [WIDTH_WORD-1:0] CMD_RUN  = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_HI = 3'd1,
        ST_LOAD_LO = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RUN_RST = 3'd4,
        ST_RUN     = 3'd5,
        ST_SEND    = 3'd6,
        ST_WAIT_TX = 3'd7
    } state_t;

    state_t                 state_reg;
    logic [PC_WIDTH-1:0]    addr_reg;
    logic [WIDTH_WORD-1:0]  instr_hi_reg;
    logic [INSTR_WIDTH-1:0] instr_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic [WIDTH_WORD-1:0]  tx_queue_reg [N_REPORT];
    logic [2:0]             tx_idx_reg;
    logic [2:0]             tx_len_reg;
    logic                   tx_start_reg;
    logic [WIDTH_WORD-1:0]  data_tx_reg;
    logic                   wr_program_reg;
    logic                   cpu_reset_reg;
    logic                   cpu_enable_reg;

    logic [CNT_WIDTH-1:0]   cnt_next;
    logic [REPORT_W-1:0]    report_vec;
    logic [WIDTH_WORD-1:0]  report_bytes [N_REPORT];
    logic                   halt_opcode;
    logic                   addr_full;
    logic [WIDTH_WORD-1:0]  ack_byte;

    // The reported count includes the halt cycle itself, so it is taken from cnt_next.
    assign cnt_next    = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
    assign report_vec  = {{(16 - PC_WIDTH){1'b0}}, i_pc, i_acc, cnt_next};
    assign halt_opcode = (instr_reg[INSTR_WIDTH-1 -: OPCODE_W] == '0);
    assign addr_full   = &addr_reg;
    assign ack_byte    = addr_reg[WIDTH_WORD-1:0] + 1'b1;

    generate
        for (genvar gi = 0; gi < N_REPORT; gi++) begin : g_report
            assign report_bytes[gi] = report_vec[(N_REPORT-1-gi)*WIDTH_WORD +: WIDTH_WORD];
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            instr_hi_reg   <= '0;
            instr_reg      <= '0;
            cnt_reg        <= '0;
            tx_idx_reg     <= '0;
            tx_len_reg     <= '0;
            tx_start_reg   <= 1'b0;
            data_tx_reg    <= '0;
            wr_program_reg <= 1'b0;
            cpu_reset_reg  <= 1'b0;
            cpu_enable_reg <= 1'b0;
            for (int i = 0; i < N_REPORT; i++) tx_queue_reg[i] <= '0;
        end else begin
            tx_start_reg   <= 1'b0;
            wr_program_reg <= 1'b0;
            cpu_reset_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (i_rx_done) begin
                        if (i_data_rx == CMD_LOAD) begin
                            addr_reg  <= '0;
                            state_reg <= ST_LOAD_HI;
                        end else if (i_data_rx == CMD_RUN) begin
                            cpu_reset_reg <= 1'b1;
                            cnt_reg       <= '0;
                            state_reg     <= ST_RUN_RST;
                        end
                    end
                end
                ST_LOAD_HI: begin
                    if (i_rx_done) begin
                        instr_hi_reg <= i_data_rx;
                        state_reg    <= ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    if (i_rx_done) begin
                        instr_reg      <= {instr_hi_reg, i_data_rx};
                        wr_program_reg <= 1'b1;
                        state_reg      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Hold at the top address: a full memory ends the load instead of wrapping.
                    if (!addr_full) addr_reg <= addr_reg + 1'b1;
                    if (halt_opcode || addr_full) begin
                        tx_queue_reg[0] <= ack_byte;
                        tx_len_reg      <= 3'd1;
                        tx_idx_reg      <= '0;
                        state_reg       <= ST_SEND;
                    end else begin
                        state_reg <= ST_LOAD_HI;
                    end
                end
                ST_RUN_RST: begin
                    cpu_enable_reg <= 1'b1;
                    state_reg      <= ST_RUN;
                end
                ST_RUN: begin
                    cnt_reg <= cnt_next;
                    if (i_halt) begin
                        cpu_enable_reg <= 1'b0;
                        for (int i = 0; i < N_REPORT; i++) tx_queue_reg[i] <= report_bytes[i];
                        tx_len_reg <= 3'(N_REPORT);
                        tx_idx_reg <= '0;
                        state_reg  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    data_tx_reg  <= tx_queue_reg[tx_idx_reg];
                    tx_start_reg <= 1'b1;
                    tx_idx_reg   <= tx_idx_reg + 1'b1;
                    state_reg    <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) state_reg <= (tx_idx_reg < tx_len_reg) ? ST_SEND : ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_tx_start     = tx_start_reg;
    assign o_data_tx      = data_tx_reg;
    assign o_wr_program   = wr_program_reg;
    assign o_addr_program = addr_reg;
    assign o_data_program = instr_reg;
    assign o_cpu_reset    = cpu_reset_reg;
    assign o_cpu_enable   = cpu_enable_reg;
    assign o_state        = state_reg;

endmodule

// File: tb/tb_debug_unit_bip.sv
// Scoreboard bench for debug_unit_bip: host commands go in, expected writes and tx bytes
// come from a command-level model and are checked by an independent monitor.
module tb_debug_unit_bip;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_rx_done;
    logic [7:0]  i_data_rx;
    logic        i_tx_done;
    logic        o_tx_start;
    logic [7:0]  o_data_tx;
    logic        o_wr_program;
    logic [10:0] o_addr_program;
    logic [15:0] o_data_program;
    logic        o_cpu_reset;
    logic        o_cpu_enable;
    logic        i_halt;
    logic [10:0] i_pc;
    logic [15:0] i_acc;
    logic [2:0]  o_state;

    always #5 clk = ~clk;

    debug_unit_bip dut (
        .i_clock(clk), .i_reset(i_reset),
        .i_rx_done(i_rx_done), .i_data_rx(i_data_rx), .i_tx_done(i_tx_done),
        .o_tx_start(o_tx_start), .o_data_tx(o_data_tx),
        .o_wr_program(o_wr_program), .o_addr_program(o_addr_program), .o_data_program(o_data_program),
        .o_cpu_reset(o_cpu_reset), .o_cpu_enable(o_cpu_enable),
        .i_halt(i_halt), .i_pc(i_pc), .i_acc(i_acc), .o_state(o_state)
    );

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    int total = 0;
    int bad   = 0;
    int max_gap = 2;

    // Core stand-in: counts enabled cycles since its reset and raises HALT on the chosen one.
    int en_count = 0;
    int halt_after = 0;
    always @(posedge clk) begin
        if (i_reset || o_cpu_reset) en_count <= 0;
        else if (o_cpu_enable)      en_count <= en_count + 1;
    end
    assign i_halt = o_cpu_enable && (halt_after > 0) && (en_count == halt_after - 1);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe and tx pulse must match the head of its queue.
    initial begin
        wr_t        w;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (o_wr_program) begin
                total++;
                if (exp_wr.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h required none", o_addr_program, o_data_program);
                end else begin
                    w = exp_wr.pop_front();
                    if (o_addr_program !== w.addr || o_data_program !== w.data) begin
                        bad++;
                        $display("FAIL write: got addr=%0h data=%0h required addr=%0h data=%0h",
                                 o_addr_program, o_data_program, w.addr, w.data);
                    end
                end
            end
            if (o_tx_start) begin
                total++;
                if (exp_tx.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_tx: got %02h required none", o_data_tx);
                end else begin
                    b = exp_tx.pop_front();
                    if (o_data_tx !== b) begin
                        bad++;
                        $display("FAIL tx_byte: got %02h required %02h", o_data_tx, b);
                    end
                end
            end
        end
    end

    // UART transmitter stand-in: finishes each byte a few cycles after the start pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_rx_done = 1'b1;
        i_data_rx = b;
        @(negedge clk);
        i_rx_done = 1'b0;
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        while (!(o_state == 3'd0 && exp_tx.size() == 0 && exp_wr.size() == 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (c >= budget) begin
            bad++;
            $display("FAIL %s_timeout: got state=%0d pending_tx=%0d pending_wr=%0d required idle",
                     name, o_state, exp_tx.size(), exp_wr.size());
            exp_tx.delete();
            exp_wr.delete();
        end
    endtask

    // Load model: writes go to consecutive addresses until a HALT opcode or the last address.
    task automatic load_program(input logic [15:0] words[$], input string name);
        int n = 0;
        foreach (words[i]) begin
            exp_wr.push_back(wr_t'{addr: 11'(n), data: words[i]});
            n++;
            if (words[i][15:11] == 5'd0 || n == 2048) break;
        end
        exp_tx.push_back(8'(n % 256));
        send_byte(8'h01);
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8]);
            send_byte(words[i][7:0]);
        end
        wait_idle(20 * n + 100, name);
        check({name, "_state"}, o_state, 0);
        $display("load %s: %0d instructions, ack %02h", name, n, n % 256);
    endtask

    task automatic run_program(input logic [10:0] pc, input logic [15:0] acc, input int n,
                               input int extras, input string name);
        int cnt = (n > 65535) ? 65535 : n;
        i_pc = pc;
        i_acc = acc;
        halt_after = n;
        exp_tx.push_back({5'b0, pc[10:8]});
        exp_tx.push_back(pc[7:0]);
        exp_tx.push_back(acc[15:8]);
        exp_tx.push_back(acc[7:0]);
        exp_tx.push_back(8'(cnt >> 8));
        exp_tx.push_back(8'(cnt));
        @(negedge clk);
        i_rx_done = 1'b1;
        i_data_rx = 8'h02;
        @(negedge clk);
        i_rx_done = 1'b0;
        check({name, "_cpu_reset"}, o_cpu_reset, 1);
        check({name, "_enable_low"}, o_cpu_enable, 0);
        @(negedge clk);
        check({name, "_cpu_reset_drop"}, o_cpu_reset, 0);
        check({name, "_enable_high"}, o_cpu_enable, 1);
        for (int i = 0; i < extras; i++) send_byte(8'($urandom));
        wait_idle(n + 200, name);
        check({name, "_state"}, o_state, 0);
        $display("run %s: pc=%03h acc=%04h cnt=%04h", name, pc, acc, cnt);
    endtask

    function automatic logic [15:0] rand_word(input bit halt_op);
        logic [4:0] op = halt_op ? 5'd0 : 5'($urandom_range(1, 31));
        return {op, 11'($urandom)};
    endfunction

    initial begin
        logic [15:0] prog[$];
        i_reset = 1'b1;
        i_rx_done = 1'b0;
        i_data_rx = '0;
        i_tx_done = 1'b0;
        i_pc = '0;
        i_acc = '0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        check("rst_state", o_state, 0);
        check("rst_tx_start", o_tx_start, 0);
        check("rst_data_tx", o_data_tx, 0);
        check("rst_wr", o_wr_program, 0);
        check("rst_addr", o_addr_program, 0);
        check("rst_data_prog", o_data_program, 0);
        check("rst_cpu_reset", o_cpu_reset, 0);
        check("rst_cpu_enable", o_cpu_enable, 0);

        prog = '{16'h0805, 16'h1003, 16'h0000};
        load_program(prog, "spec_load");
        run_program(11'h102, 16'hBEEF, 10, 0, "spec_run");

        send_byte(8'h7F);
        repeat (3) @(negedge clk);
        check("unknown_cmd_state", o_state, 0);
        $display("cmd 7f: ignored");

        for (int t = 0; t < 5; t++) begin
            int len = $urandom_range(1, 12);
            prog.delete();
            for (int i = 0; i < len; i++) prog.push_back(rand_word(i == len - 1));
            load_program(prog, "rand_load");
            run_program(11'($urandom), 16'($urandom), $urandom_range(25, 300), 3, "rand_run");
        end

        // Reset mid-RUN: the halt would come later but must never produce a report.
        i_pc = 11'h7AA;
        halt_after = 40;
        send_byte(8'h02);
        repeat (15) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check("midrun_enable", o_cpu_enable, 0);
        check("midrun_state", o_state, 0);
        i_reset = 1'b0;
        repeat (100) @(negedge clk);
        check("midrun_state_after", o_state, 0);
        $display("reset mid-run: no report");

        // Reset between HI and LO bytes: the half instruction is discarded.
        send_byte(8'h01);
        send_byte(8'h08);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check("midload_state", o_state, 0);
        i_reset = 1'b0;
        send_byte(8'h05);
        repeat (5) @(negedge clk);
        check("midload_state_after", o_state, 0);
        $display("reset mid-load: no write");

        prog = '{16'h2001, 16'h0123};
        load_program(prog, "reload");

        max_gap = 0;
        prog.delete();
        for (int i = 0; i < 2048; i++) prog.push_back(rand_word(1'b0));
        load_program(prog, "full_mem");
        max_gap = 2;

        run_program(11'h3C5, 16'h1234, 66000, 0, "saturate");

        check("queues_empty", 32'(exp_tx.size() + exp_wr.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/debug_unit_bip.md
# debug_unit_bip

Command sequencer between the UART receiver/transmitter and the BIP I core (control, datapath, program memory). It interprets bytes from `rx` as host commands, writes received instructions into program memory, runs the core until it halts, and streams PC, accumulator and cycle count back through `tx`. It replaces the ALU-era `interface_circuit` in the BIP I top level.

## Interface
Parameters:
- `WIDTH_WORD` = 8: UART byte width.
- `PC_WIDTH` = 11: program address width.
- `INSTR_WIDTH` = 16: instruction width; opcode is bits [15:11], operand bits [10:0].
- `DATA_WIDTH` = 16: accumulator width.
- `CNT_WIDTH` = 16: cycle counter width.

Ports (one clock; reset is synchronous and active-high):
- `i_clock` in 1: system clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_rx_done` in 1: one-cycle pulse; `i_data_rx` is valid.
- `i_data_rx` in 8: received byte.
- `i_tx_done` in 1: one-cycle pulse; `tx` has finished a byte.
- `o_tx_start` out 1: one-cycle pulse requesting transmission of `o_data_tx`.
- `o_data_tx` out 8: byte to transmit; held until the next `o_tx_start`.
- `o_wr_program` out 1: program-memory write strobe, one cycle.
- `o_addr_program` out 11: program-memory write address.
- `o_data_program` out 16: program-memory write data.
- `o_cpu_reset` out 1: synchronous reset to control and datapath.
- `o_cpu_enable` out 1: clock-enable to control and datapath.
- `i_halt` in 1: core decoded HALT (opcode 00000).
- `i_pc` in 11: core program counter.
- `i_acc` in 16: core accumulator.
- `o_state` out 3: current FSM state encoding, for LEDs.

## Operation
- States: IDLE=0, LOAD_HI=1, LOAD_LO=2, WRITE=3, RUN_RST=4, RUN=5, SEND=6, WAIT_TX=7.
- IDLE: on `i_rx_done`, the command is decoded.
  - 0x01 goes to LOAD_HI with address cleared to 0.
  - 0x02 goes to RUN_RST.
  - Any other byte is ignored and the FSM stays in IDLE.
- LOAD_HI: next received byte is instruction bits [15:8]. LOAD_LO: next received byte is bits [7:0], then go to WRITE.
- WRITE: drive `o_wr_program`=1 for one cycle with the current address and instruction. Then increment the address.
  - If the opcode was 00000, or the address was 2^PC_WIDTH−1, queue one ack byte equal to (instructions written) mod 256 and go to SEND.
  - Otherwise return to LOAD_HI.
- RUN_RST: `o_cpu_reset`=1 for exactly one cycle; clear the cycle counter; go to RUN.
- RUN: `o_cpu_enable`=1.
  - The counter increments every RUN cycle and saturates at 0xFFFF.
  - On the cycle `i_halt`=1 is sampled, capture `i_pc` and `i_acc`.
  - Next cycle, `o_cpu_enable` drops and the FSM enters SEND with 6 bytes queued.
- Report byte order: {5'b0, PC[10:8]}, PC[7:0], ACC[15:8], ACC[7:0], CNT[15:8], CNT[7:0].
- SEND: load the next queued byte into `o_data_tx`, pulse `o_tx_start` for one cycle, and go to WAIT_TX.
- WAIT_TX: on `i_tx_done`, go to SEND if bytes remain, otherwise go to IDLE.
- Bytes received in RUN_RST, RUN, SEND or WAIT_TX are dropped.
- The address does not wrap within a load; the full-memory condition terminates the load.

## Timing
- Reset values: all outputs 0, `o_state`=IDLE, address 0, counter 0, byte queue empty.
- Reset asserted in any state, including mid-load, RUN or WAIT_TX:
  - outputs go to their reset values on the next edge;
  - a partial instruction is discarded;
  - no pending tx byte is sent.
- LOAD_LO `i_rx_done` → `o_wr_program` on the next cycle, exactly one cycle wide.
- Command 0x02 `i_rx_done` → `o_cpu_reset` on the next cycle, then `o_cpu_enable` the cycle after.
- CNT equals the number of cycles `o_cpu_enable` was high, including the halt cycle.
- `i_halt` captured on cycle N → `o_cpu_enable`=0 at N+1 → first `o_tx_start` at N+2.
- `i_tx_done` → next `o_tx_start` is 2 cycles later (WAIT_TX→SEND→pulse).
- `i_rx_done` arriving on the same cycle as `i_tx_done` is ignored; `i_tx_done` takes priority.

## Test plan
- Reset check: apply reset mid-RUN → next cycle `o_cpu_enable`=0, `o_state`=0, `o_tx_start` never pulses.
- Load program: send 0x01, 0x08,0x05, 0x10,0x03, 0x00,0x00.
  - Writes required: addr 0 = 0x0805, addr 1 = 0x1003, addr 2 = 0x0000.
  - Tx required: single byte 0x03.
- Run program: send 0x02 with a core model that halts after 10 enabled cycles at PC=0x102, ACC=0xBEEF.
  - Tx required: 0x01, 0x02, 0xBE, 0xEF, 0x00, 0x0A.
- Unknown command and dropped bytes: send 0x7F → no writes, no tx, state stays 0; send bytes during RUN → they are ignored and the report is unchanged.
- Full memory: load 2048 non-HALT instructions → the last write is at addr 0x7FF, then ack 0x00 and return to IDLE.
- Saturation and reset mid-load:
  - Run a core that halts after 70000 cycles → CNT bytes are 0xFF,0xFF.
  - Apply reset between the HI and LO bytes of a load → no `o_wr_program` occurs.
